enigma_step_ctrl: RTL and testbench

- Character-level sequencer for the Enigma datapath. Accepts one ASCII character per handshake.
- Before each encryption, steps the rotor positions with notch/turnover rules.
- Drives one shared substitution unit through forward rotors, reflector, then backward rotors, issuing one request per stage.
- Sits between the host-side character stream and the rotor/reflector substitution units.

---
 rtl/enigma_step_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_enigma_step_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enigma_step_ctrl
// Brief    : Enigma character sequencer: steps rotors, then walks one shared
//            substitution unit forward, through the reflector and backward.
// Options  : define DOUBLE_STEP_EN to enable the middle-rotor double step.
// Revision : 1.0 - initial release
// ============================================================================
module enigma_step_ctrl #(
    parameter int NUM_ROT = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_sel,
    input  logic [4:0]           cfg_pos,
    input  logic [4:0]           cfg_notch,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_char,
    output logic                 sub_req,
    output logic [2:0]           sub_stage,
    output logic                 sub_dir,
    output logic [4:0]           sub_offset,
    output logic [7:0]           sub_din,
    input  logic                 sub_done,
    input  logic [7:0]           sub_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_char,
    output logic [5*NUM_ROT-1:0] rot_pos,
    output logic                 busy,
    output logic                 err
);
    localparam int C_TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_pos   [NUM_ROT];
    logic [4:0]        r_notch [NUM_ROT];
    logic [7:0]        r_data;
    logic [7:0]        r_out_char;
    logic [2:0]        r_stage;
    logic [C_TW-1:0]   r_tcnt;
    logic              r_err;
    logic [NUM_ROT-1:0] w_step;
    logic              w_carry;
    logic              w_is_letter;
    logic              w_last;
    logic              w_tmo;
    logic [2:0]        w_rot_idx;
    logic [4:0]        w_off;

    assign w_is_letter = (in_char >= 8'h41) && (in_char <= 8'h5A);
    assign w_last      = (r_stage == 3'(2 * NUM_ROT));
    assign w_tmo       = (r_tcnt == C_TW'(TIMEOUT - 1));

    // Stepping decisions use pre-step positions only
    always_comb begin
        w_step    = '0;
        w_step[0] = 1'b1;
        w_carry   = 1'b1;
        for (int i = 1; i < NUM_ROT; i++) begin
`ifdef DOUBLE_STEP_EN
            w_step[i] = (r_pos[i-1] == r_notch[i-1]) ||
                        ((i < NUM_ROT - 1) && (r_pos[i] == r_notch[i]));
`else
            w_carry   = w_carry && (r_pos[i-1] == r_notch[i-1]);
            w_step[i] = w_carry;
`endif
        end
    end

    // Stage index folds back after the reflector: 0,1,..,N,..,1,0
    always_comb begin
        w_rot_idx = (r_stage <= 3'(NUM_ROT)) ? r_stage : 3'(2 * NUM_ROT) - r_stage;
        w_off     = 5'd0;
        for (int i = 0; i < NUM_ROT; i++) begin
            if (w_rot_idx == 3'(i) && r_stage != 3'(NUM_ROT)) begin
                w_off = r_pos[i];
            end
        end
    end

    always_comb begin
        rot_pos = '0;
        for (int i = 0; i < NUM_ROT; i++) begin
            rot_pos[5*i +: 5] = r_pos[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = w_is_letter ? S_STEP : S_OUT;
            S_STEP:  w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (sub_done) begin
                    w_next = w_last ? S_OUT : S_ISSUE;
                end else if (w_tmo) begin
                    w_next = S_IDLE;
                end
            end
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ROT; i++) begin
                r_pos[i]   <= 5'd0;
                r_notch[i] <= 5'd0;
            end
        end else if (r_state == S_IDLE) begin
            for (int i = 0; i < NUM_ROT; i++) begin
                if (cfg_we && cfg_sel == 2'(i)) begin
                    r_pos[i]   <= cfg_pos;
                    r_notch[i] <= cfg_notch;
                end
            end
        end else if (r_state == S_STEP) begin
            for (int i = 0; i < NUM_ROT; i++) begin
                if (w_step[i]) begin
                    r_pos[i] <= (r_pos[i] == 5'd25) ? 5'd0 : r_pos[i] + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data     <= 8'h00;
            r_out_char <= 8'h00;
            r_stage    <= 3'd0;
            r_tcnt     <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_char;
                        if (!w_is_letter) r_out_char <= in_char;
                    end
                end
                S_STEP:  r_stage <= 3'd0;
                S_ISSUE: r_tcnt  <= '0;
                S_WAIT: begin
                    if (sub_done) begin
                        r_data <= sub_dout;
                        if (w_last) r_out_char <= sub_dout;
                        else        r_stage    <= r_stage + 3'd1;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + C_TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = (r_state == S_OUT);
    assign sub_req    = (r_state == S_ISSUE);
    assign sub_stage  = w_rot_idx;
    assign sub_dir    = (r_stage > 3'(NUM_ROT));
    assign sub_offset = w_off;
    assign sub_din    = r_data;
    assign out_char   = r_out_char;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_enigma_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_enigma_step_ctrl
// Brief    : Scoreboard bench for enigma_step_ctrl with a +1 substitution stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enigma_step_ctrl;
    localparam int NUM_ROT = 3;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [4:0]  cfg_pos = 5'd0;
    logic [4:0]  cfg_notch = 5'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'h00;
    logic        sub_req;
    logic [2:0]  sub_stage;
    logic        sub_dir;
    logic [4:0]  sub_offset;
    logic [7:0]  sub_din;
    logic        sub_done = 1'b0;
    logic [7:0]  sub_dout = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_char;
    logic [14:0] rot_pos;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    enigma_step_ctrl #(.NUM_ROT(NUM_ROT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_pos(cfg_pos), .cfg_notch(cfg_notch), .in_valid(in_valid),
        .in_ready(in_ready), .in_char(in_char), .sub_req(sub_req),
        .sub_stage(sub_stage), .sub_dir(sub_dir), .sub_offset(sub_offset),
        .sub_din(sub_din), .sub_done(sub_done), .sub_dout(sub_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .rot_pos(rot_pos), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [2:0] stage;
        logic       dir;
        logic [4:0] offset;
        logic [7:0] din;
    } req_t;

    req_t        req_q[$];
    logic [7:0]  out_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_cnt = 0;
    int          drop_from = 1000000;
    logic        force_done = 1'b0;
    logic        pend = 1'b0;
    logic [7:0]  pend_val = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] stub_f(input logic [7:0] c);
        return (c == 8'h5A) ? 8'h41 : c + 8'd1;
    endfunction

    function automatic logic [14:0] pos3(input logic [4:0] p0, input logic [4:0] p1,
                                         input logic [4:0] p2);
        return {p2, p1, p0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] sel, input logic [4:0] pos, input logic [4:0] notch);
        cfg_we = 1'b1; cfg_sel = sel; cfg_pos = pos; cfg_notch = notch;
        tick();
        cfg_we = 1'b0;
    endtask

    // Expected stage requests for a letter given post-step positions
    task automatic push_reqs(input logic [7:0] c, input logic [4:0] p0, input logic [4:0] p1,
                             input logic [4:0] p2, input int nreq);
        logic [4:0] pp [3];
        logic [7:0] d;
        req_t       e;
        int         r;
        pp[0] = p0; pp[1] = p1; pp[2] = p2; d = c;
        for (int s = 0; s < nreq; s++) begin
            r = (s <= NUM_ROT) ? s : 2 * NUM_ROT - s;
            e.stage = 3'(r);
            e.dir   = (s > NUM_ROT);
            if (s == NUM_ROT) e.offset = 5'd0;
            else              e.offset = pp[r];
            e.din = d;
            req_q.push_back(e);
            d = stub_f(d);
        end
    endtask

    task automatic send(input logic [7:0] c, output int t_acc);
        int n;
        in_valid = 1'b1; in_char = c; n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("in_ready_at_send", 32'(in_ready), 32'd1);
        t_acc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check("out_valid_arrives", 32'(out_valid), 32'd1);
        t = cyc;
    endtask

    // Substitution stub (1-cycle response) and request monitor
    initial begin : stub_mon
        req_t e;
        forever begin
            @(negedge clk);
            sub_done = pend | force_done;
            sub_dout = pend ? pend_val : 8'h00;
            pend = 1'b0;
            if (sub_req) begin
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sub_req: got stage=%0d dir=%0d required none",
                             sub_stage, sub_dir);
                end else begin
                    e = req_q.pop_front();
                    if ({sub_stage, sub_dir, sub_offset, sub_din} !== e) begin
                        errors++;
                        $display("FAIL sub_req: got st=%0d dir=%0d off=%0d din=%h required st=%0d dir=%0d off=%0d din=%h",
                                 sub_stage, sub_dir, sub_offset, sub_din,
                                 e.stage, e.dir, e.offset, e.din);
                    end
                end
                if (req_cnt < drop_from) begin
                    pend = 1'b1;
                    pend_val = stub_f(sub_din);
                end
                req_cnt++;
            end
        end
    end

    initial begin : out_mon
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (out_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got 0x%h required none", out_char);
                end else begin
                    exp = out_q.pop_front();
                    if (out_char !== exp) begin
                        errors++;
                        $display("FAIL out_char: got 0x%h required 0x%h", out_char, exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int ta, to, n;
        logic [4:0] e0, e1, e2;

        tick(); tick();
        check("rst_rot_pos", 32'(rot_pos), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sub_req", 32'(sub_req), 32'd0);
        reset_n = 1'b1;
        tick();

        // All notches 0 after reset: every rotor carries
        push_reqs("A", 5'd1, 5'd1, 5'd1, 7);
        out_q.push_back("H");
        send("A", ta);
        wait_out(to);
        check("latency_A", 32'(to - ta), 32'd16);
        tick();
        check("pos_after_A", 32'(rot_pos), 32'(pos3(5'd1, 5'd1, 5'd1)));
        check("in_ready_after_out", 32'(in_ready), 32'd1);

        // Rotor 0 wrap with carry; config written in the handshake cycle
        set_cfg(2'd1, 5'd0, 5'd10);
        set_cfg(2'd2, 5'd0, 5'd10);
        push_reqs("B", 5'd0, 5'd1, 5'd0, 7);
        out_q.push_back("I");
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_pos = 5'd25; cfg_notch = 5'd25;
        send("B", ta);
        cfg_sel = 2'd1; cfg_pos = 5'd7; cfg_notch = 5'd7;
        tick();
        cfg_we = 1'b0;
        wait_out(to);
        tick();
        check("pos_after_B", 32'(rot_pos), 32'(pos3(5'd0, 5'd1, 5'd0)));

        set_cfg(2'd3, 5'd7, 5'd7);
        check("cfg_sel3_ignored", 32'(rot_pos), 32'(pos3(5'd0, 5'd1, 5'd0)));

        // Middle rotor at its own notch, rotor 0 not at notch
        set_cfg(2'd0, 5'd3, 5'd10);
        set_cfg(2'd1, 5'd4, 5'd4);
        set_cfg(2'd2, 5'd0, 5'd0);
`ifdef DOUBLE_STEP_EN
        e0 = 5'd4; e1 = 5'd5; e2 = 5'd1;
`else
        e0 = 5'd4; e1 = 5'd4; e2 = 5'd0;
`endif
        push_reqs("C", e0, e1, e2, 7);
        out_q.push_back("J");
        send("C", ta);
        wait_out(to);
        tick();
        check("pos_after_C", 32'(rot_pos), 32'(pos3(e0, e1, e2)));

        // Full carry chain, every rotor wraps
        set_cfg(2'd0, 5'd25, 5'd25);
        set_cfg(2'd1, 5'd25, 5'd25);
        set_cfg(2'd2, 5'd25, 5'd0);
        push_reqs("X", 5'd0, 5'd0, 5'd0, 7);
        out_q.push_back("E");
        send("X", ta);
        wait_out(to);
        tick();
        check("pos_after_X", 32'(rot_pos), 32'd0);

        // Non-letter bypass with downstream backpressure
        out_ready = 1'b0;
        out_q.push_back(8'h35);
        send(8'h35, ta);
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_char", 32'(out_char), 32'h35);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bypass_in_ready", 32'(in_ready), 32'd1);
        check("bypass_out_valid", 32'(out_valid), 32'd0);
        out_q.push_back(8'h40);
        send(8'h40, ta);
        wait_out(to);
        tick();
        out_q.push_back(8'h5B);
        send(8'h5B, ta);
        wait_out(to);
        tick();
        check("pos_after_bypass", 32'(rot_pos), 32'd0);

        // Stage timeout: first request is never answered
        drop_from = req_cnt;
        push_reqs("D", 5'd1, 5'd0, 5'd0, 1);
        send("D", ta);
        n = 0;
        while (!err && n < 400) begin tick(); n++; end
        check("err_set", 32'(err), 32'd1);
        check("timeout_latency", 32'(cyc - ta), 32'd258);
        check("timeout_idle", 32'(in_ready), 32'd1);
        check("timeout_no_out", 32'(out_valid), 32'd0);
        check("pos_after_timeout", 32'(rot_pos), 32'(pos3(5'd1, 5'd0, 5'd0)));
        drop_from = 1000000;
        push_reqs("E", 5'd2, 5'd0, 5'd0, 7);
        out_q.push_back("L");
        send("E", ta);
        wait_out(to);
        tick();
        check("err_sticky", 32'(err), 32'd1);

        // Reset while waiting on stage 4
        drop_from = req_cnt + 4;
        push_reqs("F", 5'd3, 5'd0, 5'd0, 5);
        send("F", ta);
        n = 0;
        while (!(sub_req && sub_stage == 3'd2 && sub_dir) && n < 100) begin tick(); n++; end
        check("reached_stage4", 32'(sub_req), 32'd1);
        tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_rot_pos", 32'(rot_pos), 32'd0);
        check("mid_rst_sub_bus", 32'({sub_req, sub_stage, sub_dir, sub_offset, sub_din}), 32'd0);
        check("mid_rst_out", 32'({out_valid, out_char}), 32'd0);
        drop_from = 1000000;
        force_done = 1'b1;
        tick(); tick();
        force_done = 1'b0;
        tick();
        check("late_done_ignored", 32'({busy, out_valid}), 32'd0);

        push_reqs("A", 5'd1, 5'd1, 5'd1, 7);
        out_q.push_back("H");
        send("A", ta);
        wait_out(to);
        tick();
        tick();
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("out_q_drained", 32'(out_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
